// File: rtl/count_seq_pkg.sv
// Shared definitions for the counter sequence driver: FSM state encoding.
package count_seq_pkg;
  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_UP    = 3'd1,
    ST_DOWN  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;
endpackage

// File: rtl/count_ref_model.sv
// Golden copy of the up/down counter contract: wraps modulo 2^WIDTH and
// flags ovflw for exactly the cycle after a wrap.
module count_ref_model #(
  parameter int WIDTH = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_act,
  input  logic             i_up_dwn_n,
  output logic [WIDTH-1:0] o_model,
  output logic             o_exp_ov
);
  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_model;
  logic             r_exp_ov;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_model  <= '0;
      r_exp_ov <= 1'b0;
    end else if (i_act) begin
      if (i_up_dwn_n) begin
        r_model  <= r_model + ONE;
        r_exp_ov <= (r_model == MAX);
      end else begin
        r_model  <= r_model - ONE;
        r_exp_ov <= (r_model == '0);
      end
    end else begin
      r_exp_ov <= 1'b0;
    end
  end

  assign o_model  = r_model;
  assign o_exp_ov = r_exp_ov;
endmodule

// File: rtl/count_seq_driver.sv
// Drives an up-then-down burst into an external counter and checks its
// count/ovflw every busy/done cycle against count_ref_model.
module count_seq_driver
  import count_seq_pkg::*;
#(
  parameter int WIDTH  = 5,
  parameter int LEN_W  = 8,
  parameter int ECNT_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [LEN_W-1:0]  i_up_len,
  input  logic [LEN_W-1:0]  i_dn_len,
  output logic              o_act,
  output logic              o_up_dwn_n,
  input  logic [WIDTH-1:0]  i_count,
  input  logic              i_ovflw,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [ECNT_W-1:0] o_err_cnt,
  output logic [WIDTH-1:0]  o_first_bad
);
  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
  localparam logic [ECNT_W-1:0] ECNT_ONE = ECNT_W'(1);

  state_e              r_state;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_dn_len;
  logic                r_act;
  logic                r_up_dwn_n;
  logic                r_busy;
  logic                r_done;
  logic                r_err;
  logic [ECNT_W-1:0]   r_err_cnt;
  logic [WIDTH-1:0]    r_first_bad;

  logic [WIDTH-1:0]    w_model;
  logic                w_exp_ov;
  logic                w_accept;
  logic                w_len_last;
  logic                w_mismatch;

  count_ref_model #(.WIDTH(WIDTH)) u_ref (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_act      (r_act),
    .i_up_dwn_n (r_up_dwn_n),
    .o_model    (w_model),
    .o_exp_ov   (w_exp_ov)
  );

  assign w_accept   = (r_state == ST_IDLE) && i_start;
  assign w_len_last = (r_len == LEN_ONE);
  assign w_mismatch = (r_busy || r_done) &&
                      ((i_count != w_model) || (i_ovflw != w_exp_ov));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_len      <= '0;
      r_dn_len   <= '0;
      r_act      <= 1'b0;
      r_up_dwn_n <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_dn_len <= i_dn_len;
            r_busy   <= 1'b1;
            if (i_up_len != '0) begin
              r_state    <= ST_UP;
              r_len      <= i_up_len;
              r_act      <= 1'b1;
              r_up_dwn_n <= 1'b1;
            end else if (i_dn_len != '0) begin
              r_state    <= ST_DOWN;
              r_len      <= i_dn_len;
              r_act      <= 1'b1;
              r_up_dwn_n <= 1'b0;
            end else begin
              // Empty burst still spends one busy cycle so done follows busy.
              r_state <= ST_DRAIN;
              r_act   <= 1'b0;
            end
          end
        end
        ST_UP: begin
          r_len <= r_len - LEN_ONE;
          if (w_len_last) begin
            if (r_dn_len != '0) begin
              r_state    <= ST_DOWN;
              r_len      <= r_dn_len;
              r_up_dwn_n <= 1'b0;
            end else begin
              r_state <= ST_DRAIN;
              r_act   <= 1'b0;
            end
          end
        end
        ST_DOWN: begin
          r_len <= r_len - LEN_ONE;
          if (w_len_last) begin
            r_state <= ST_DRAIN;
            r_act   <= 1'b0;
          end
        end
        ST_DRAIN: begin
          r_state <= ST_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_act   <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Accept only happens in IDLE, where busy/done are low, so it never races a mismatch.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_err       <= 1'b0;
      r_err_cnt   <= '0;
      r_first_bad <= '0;
    end else if (w_accept) begin
      r_err       <= 1'b0;
      r_err_cnt   <= '0;
      r_first_bad <= '0;
    end else if (w_mismatch) begin
      r_err <= 1'b1;
      if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + ECNT_ONE;
      if (!r_err) r_first_bad <= i_count;
    end
  end

  assign o_act       = r_act;
  assign o_up_dwn_n  = r_up_dwn_n;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_err_cnt   = r_err_cnt;
  assign o_first_bad = r_first_bad;
endmodule

// File: tb/tb_count_seq_driver.sv
// Directed bench for count_seq_driver with a behavioural up/down counter attached.
module tb_count_seq_driver;
  localparam int WIDTH  = 5;
  localparam int LEN_W  = 8;
  localparam int ECNT_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [LEN_W-1:0]  up_len, dn_len;
  logic              act, up_dwn_n, ovflw, busy, done, err;
  logic [WIDTH-1:0]  count, first_bad, cnt_q;
  logic              ov_q;
  logic              frc;
  logic [ECNT_W-1:0] err_cnt;

  int errors = 0;
  int checks = 0;

  int               m_busy, m_done, m_done_at, m_ov, m_ov_at;
  bit               m_act;
  logic [WIDTH-1:0] m_trace [0:63];

  always #5 clk = ~clk;

  // Counter under test: same contract the driver checks against.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      ov_q  <= 1'b0;
    end else if (act) begin
      if (up_dwn_n) begin
        cnt_q <= cnt_q + 5'd1;
        ov_q  <= (cnt_q == 5'd31);
      end else begin
        cnt_q <= cnt_q - 5'd1;
        ov_q  <= (cnt_q == 5'd0);
      end
    end else begin
      ov_q <= 1'b0;
    end
  end

  assign count = cnt_q ^ {{(WIDTH-1){1'b0}}, frc};
  assign ovflw = ov_q;

  count_seq_driver #(.WIDTH(WIDTH), .LEN_W(LEN_W), .ECNT_W(ECNT_W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start     (start),
    .i_up_len    (up_len),
    .i_dn_len    (dn_len),
    .o_act       (act),
    .o_up_dwn_n  (up_dwn_n),
    .i_count     (count),
    .i_ovflw     (ovflw),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err),
    .o_err_cnt   (err_cnt),
    .o_first_bad (first_bad)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Cycle k is observed at the k-th negedge after start is accepted.
  task automatic run_seq(input int up, input int dn, input int restart_at,
                         input int frc_from, input int frc_to);
    m_busy = 0; m_done = 0; m_done_at = 0; m_ov = 0; m_ov_at = 0; m_act = 0;
    @(negedge clk);
    start = 1'b1; up_len = LEN_W'(up); dn_len = LEN_W'(dn);
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) m_busy++;
      if (done) begin
        if (m_done == 0) m_done_at = k;
        m_done++;
      end
      if (ovflw) begin
        if (m_ov == 0) m_ov_at = k;
        m_ov++;
      end
      if (act) m_act = 1;
      if (k < 64) m_trace[k] = count;
      if (k == restart_at) begin
        start = 1'b1; up_len = 8'd20; dn_len = 8'd20;
      end
      frc = (k >= frc_from) && (k <= frc_to);
      if (m_done > 0 && k >= m_done_at + 3) break;
    end
    start = 1'b0;
    frc   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; up_len = '0; dn_len = '0; frc = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (act !== 1'b0) begin errors++; $display("FAIL reset_act: got %0b expected 0", act); end
    checks++; if (up_dwn_n !== 1'b1) begin errors++; $display("FAIL reset_updn: got %0b expected 1", up_dwn_n); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %0b/%0b expected 0/0", busy, done); end
    checks++; if (err !== 1'b0 || err_cnt !== 8'd0 || first_bad !== 5'd0) begin
      errors++; $display("FAIL reset_err: got err=%0b cnt=%0d fb=%0d expected 0/0/0", err, err_cnt, first_bad); end
    rst = 1'b0;
  endtask

  task automatic test_long_up();
    run_seq(40, 0, 0, 0, 0);
    checks++; if (m_busy !== 41) begin errors++; $display("FAIL up40_busy: got %0d expected 41", m_busy); end
    checks++; if (m_ov !== 1 || m_ov_at !== 33) begin errors++; $display("FAIL up40_ovflw: got n=%0d at=%0d expected 1 at 33", m_ov, m_ov_at); end
    checks++; if (count !== 5'd8) begin errors++; $display("FAIL up40_count: got %0d expected 8", count); end
    checks++; if (m_done !== 1 || m_done_at !== 42) begin errors++; $display("FAIL up40_done: got n=%0d at=%0d expected 1 at 42", m_done, m_done_at); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL up40_err: got %0b expected 0", err); end
  endtask

  task automatic test_up_down();
    int exp_tr [11];
    exp_tr = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 31, 30};
    do_reset();
    run_seq(4, 6, 0, 0, 0);
    for (int k = 0; k < 11; k++) begin
      checks++;
      if (m_trace[k+1] !== WIDTH'(exp_tr[k])) begin
        errors++; $display("FAIL updn_trace[%0d]: got %0d expected %0d", k + 1, m_trace[k+1], exp_tr[k]); end
    end
    checks++; if (m_ov !== 1 || m_ov_at !== 10) begin errors++; $display("FAIL updn_ovflw: got n=%0d at=%0d expected 1 at 10", m_ov, m_ov_at); end
    checks++; if (m_busy !== 11) begin errors++; $display("FAIL updn_busy: got %0d expected 11", m_busy); end
    checks++; if (m_done !== 1) begin errors++; $display("FAIL updn_done: got %0d expected 1", m_done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL updn_err: got %0b expected 0", err); end
  endtask

  task automatic test_empty();
    run_seq(0, 0, 0, 0, 0);
    checks++; if (m_busy !== 1) begin errors++; $display("FAIL empty_busy: got %0d expected 1", m_busy); end
    checks++; if (m_done !== 1 || m_done_at !== 2) begin errors++; $display("FAIL empty_done: got n=%0d at=%0d expected 1 at 2", m_done, m_done_at); end
    checks++; if (m_act !== 1'b0) begin errors++; $display("FAIL empty_act: got %0b expected 0", m_act); end
    checks++; if (count !== 5'd30) begin errors++; $display("FAIL empty_count: got %0d expected 30", count); end
  endtask

  task automatic test_force_error();
    run_seq(10, 0, 0, 5, 7);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL force_err: got %0b expected 1", err); end
    checks++; if (err_cnt !== 8'd3) begin errors++; $display("FAIL force_errcnt: got %0d expected 3", err_cnt); end
    checks++; if (first_bad !== 5'd3) begin errors++; $display("FAIL force_firstbad: got %0d expected 3", first_bad); end
    @(negedge clk);
    start = 1'b1; up_len = 8'd1; dn_len = 8'd1;
    @(negedge clk);
    start = 1'b0;
    checks++; if (err !== 1'b0 || err_cnt !== 8'd0 || first_bad !== 5'd0) begin
      errors++; $display("FAIL force_clear: got err=%0b cnt=%0d fb=%0d expected 0/0/0", err, err_cnt, first_bad); end
    repeat (6) @(negedge clk);
    checks++; if (err !== 1'b0 || count !== 5'd8) begin errors++; $display("FAIL force_rerun: got err=%0b count=%0d expected 0/8", err, count); end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    start = 1'b1; up_len = 8'd10; dn_len = 8'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (act !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL midrst_pre: got act=%0b busy=%0b expected 1/1", act, busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (act !== 1'b0 || up_dwn_n !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL midrst_ctl: got act=%0b ud=%0b busy=%0b done=%0b expected 0/1/0/0", act, up_dwn_n, busy, done); end
    checks++; if (err !== 1'b0 || err_cnt !== 8'd0 || first_bad !== 5'd0 || count !== 5'd0) begin
      errors++; $display("FAIL midrst_err: got err=%0b cnt=%0d fb=%0d count=%0d expected all 0", err, err_cnt, first_bad, count); end
    run_seq(3, 2, 0, 0, 0);
    checks++; if (m_busy !== 6 || m_done !== 1) begin errors++; $display("FAIL midrst_rerun: got busy=%0d done=%0d expected 6/1", m_busy, m_done); end
    checks++; if (count !== 5'd1 || err !== 1'b0) begin errors++; $display("FAIL midrst_final: got count=%0d err=%0b expected 1/0", count, err); end
  endtask

  task automatic test_back_to_back();
    run_seq(5, 3, 3, 0, 0);
    checks++; if (m_busy !== 9) begin errors++; $display("FAIL busy_restart_busy: got %0d expected 9", m_busy); end
    checks++; if (m_done !== 1) begin errors++; $display("FAIL busy_restart_done: got %0d expected 1", m_done); end
    checks++; if (count !== 5'd3 || err !== 1'b0) begin errors++; $display("FAIL busy_restart_final: got count=%0d err=%0b expected 3/0", count, err); end
    run_seq(2, 0, 4, 0, 0);
    checks++; if (m_busy !== 3 || m_done !== 1 || m_done_at !== 4) begin
      errors++; $display("FAIL done_restart: got busy=%0d done=%0d at=%0d expected 3/1/4", m_busy, m_done, m_done_at); end
    checks++; if (count !== 5'd5) begin errors++; $display("FAIL done_restart_count: got %0d expected 5", count); end
  endtask

  initial begin
    test_reset();
    test_long_up();
    test_up_down();
    test_empty();
    test_force_error();
    test_mid_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
